sky130_ajc_ip__por_seq: RTL
===========================

SKY130_AJC_IP__POR_SEQ -- requirements
Module: sky130_ajc_ip__por_seq

Interface
REQ-001 SHALL have parameter N_STG, default 3, number of sequenced reset stages (1..8).
REQ-002 SHALL have parameter SETTLE, default 16, osc_ck cycles waited after reset release before stage 0.
REQ-003 SHALL have parameter TMO, default 255, maximum osc_ck cycles waited for a stage ack.
REQ-004 SHALL have port osc_ck  in  1  sole clock, RC oscillator output.
REQ-005 SHALL have port porb  in  1  reset; asynchronous, active-low, driven by POR porb.
REQ-006 SHALL have port ack  in  N_STG  per-stage domain-ready level; asynchronous, synchronized internally.
REQ-007 SHALL have port dly_cfg  in  8  inter-stage gap in osc_ck cycles; quasi-static.
REQ-008 SHALL have port soft_rst_req  in  1  single-cycle synchronous sequence-restart request.
REQ-009 SHALL have port force_short_oneshot  in  1  debug; collapses SETTLE and gaps to 1 cycle.
REQ-010 SHALL have port rst_n_out  out  N_STG  staged active-low domain resets.
REQ-011 SHALL have port done  out  1  all stages released and acknowledged.
REQ-012 SHALL have port seq_err  out  1  ack timeout occurred.
REQ-013 SHALL have port state  out  3  current FSM state encoding, debug.

Function
REQ-014 SHALL synchronize porb deassertion through a 2-flop synchronizer (async clear); internal reset rst_sync_n rises on the 2nd osc_ck rising edge after porb rises.
REQ-015 SHALL synchronize each ack bit through 2 flops; all ack decisions use synchronized values.
REQ-016 SHALL implement states RESET(0), SETTLE(1), RELEASE(2), WAIT_ACK(3), GAP(4), DONE(5), FAULT(6).
REQ-017 RESET -> SETTLE on first cycle with rst_sync_n high.
REQ-018 SETTLE SHALL count SETTLE cycles (1 if force_short_oneshot), capture dly_cfg, set idx=0, then -> RELEASE.
REQ-019 RELEASE SHALL set rst_n_out[idx]=1 for exactly one cycle of state occupancy, clear timeout counter, -> WAIT_ACK.
REQ-020 WAIT_ACK: synced ack[idx]=1 -> GAP if idx<N_STG-1, else DONE; counter reaching TMO without ack -> FAULT.
REQ-021 Ack and timeout in the same cycle SHALL resolve as ack.
REQ-022 GAP SHALL wait captured dly_cfg cycles (0 = zero extra cycles; 1 if force_short_oneshot), increment idx, -> RELEASE.
REQ-023 DONE SHALL assert done=1, all rst_n_out=1; later ack deassertion ignored.
REQ-024 FAULT SHALL assert seq_err=1, keep already-released stages high, keep remaining stages low; sticky until soft_rst_req or porb.
REQ-025 soft_rst_req in any state except RESET SHALL, next cycle, drive all rst_n_out=0, clear done, seq_err, idx, and enter SETTLE.
REQ-026 Stages SHALL release strictly in ascending index order, never two in the same cycle.
REQ-027 Counters SHALL be sized by $clog2 of their maximum and SHALL saturate, never wrap.

Reset
REQ-028 porb low SHALL immediately (asynchronously) force rst_n_out=0, done=0, seq_err=0, state=RESET, counters and idx=0.
REQ-029 porb low mid-sequence SHALL abort and, after release, restart from RESET with no retained state.

Structure
REQ-030 State encoding and default SETTLE/TMO constants SHALL live in shared package sky130_ajc_ip__por_pkg.
REQ-031 The porb synchronizer SHALL be sub-module sky130_ajc_ip__por_rsync, reused for the ack synchronizers.

Verification
REQ-032 porb 0->1, ack tied high, dly_cfg=4, N_STG=3 -> rst_n_out[0] high 2+SETTLE+1 cycles after porb rise; stages spaced by 2 sync + 4 gap + 1 cycles; done=1 after stage 2.
REQ-033 ack[1] held low -> seq_err=1 exactly TMO cycles after WAIT_ACK entry; rst_n_out=3'b011; state=6.
REQ-034 FAULT then soft_rst_req pulse -> rst_n_out=0 next cycle, seq_err=0, full sequence repeats to done.
REQ-035 porb dropped during GAP of stage 1 -> rst_n_out=0 same timestep without clock; full restart after porb rises.
REQ-036 force_short_oneshot=1, dly_cfg=255 -> stage 0 released 4 cycles after porb rise; gaps 1 cycle.
REQ-037 ack[idx] rising in the exact cycle timeout expires -> no FAULT, sequence proceeds.

Source files
------------

// File: rtl/sky130_ajc_ip__por_pkg.sv
// Shared definitions for the power-on reset sequencer: state encoding,
// default timing constants and small elaboration helpers.
package sky130_ajc_ip__por_pkg;

  localparam int unsigned SETTLE_DEF = 16;
  localparam int unsigned TMO_DEF    = 255;
  localparam int unsigned DLY_W      = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET    = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } por_state_e;

  // Largest of three counts; sizes the shared wait counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sky130_ajc_ip__por_rsync.sv
// Two-flop synchronizer with asynchronous clear; used for the porb release
// and for the per-stage ack levels.
module sky130_ajc_ip__por_rsync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sky130_ajc_ip__por_seq.sv
// Power-on reset sequencer: releases N_STG domain resets one at a time in
// ascending order, each gated by a synchronized ack, with timeout fault.
module sky130_ajc_ip__por_seq
  import sky130_ajc_ip__por_pkg::*;
#(
  parameter int unsigned N_STG  = 3,
  parameter int unsigned SETTLE = SETTLE_DEF,
  parameter int unsigned TMO    = TMO_DEF
) (
  input  logic               osc_ck,
  input  logic               porb,
  input  logic [N_STG-1:0]   ack,
  input  logic [DLY_W-1:0]   dly_cfg,
  input  logic               soft_rst_req,
  input  logic               force_short_oneshot,
  output logic [N_STG-1:0]   rst_n_out,
  output logic               done,
  output logic               seq_err,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned IDX_W       = (N_STG > 1) ? $clog2(N_STG) : 1;
  localparam int unsigned CNT_MAX     = max3(SETTLE, TMO, (2 ** DLY_W) - 1);
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned TMO_LAST    = (TMO > 0) ? TMO - 1 : 0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STG - 1);

  logic             rst_sync_n;
  logic [N_STG-1:0] ack_s;

  por_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [N_STG-1:0] rst_out_d;
  logic             done_d;
  logic             err_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] gap_len;
  logic             settle_end;
  logic             gap_end;
  logic             tmo_end;

  sky130_ajc_ip__por_rsync #(.W(1)) u_por_sync (
    .clk   (osc_ck),
    .rst_n (porb),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sky130_ajc_ip__por_rsync #(.W(N_STG)) u_ack_sync (
    .clk   (osc_ck),
    .rst_n (porb),
    .d     (ack),
    .q     (ack_s)
  );

  // Saturating counter step and per-state terminal conditions.
  assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign idx_inc    = idx_q + IDX_W'(1);
  assign gap_len    = force_short_oneshot ? CNT_W'(1) : CNT_W'(dly_q);
  assign settle_end = force_short_oneshot || (cnt_q >= CNT_W'(SETTLE_LAST));
  assign gap_end    = cnt_q >= gap_len;
  assign tmo_end    = cnt_q >= CNT_W'(TMO_LAST);

  // State register and all registered outputs.
  always_ff @(posedge osc_ck or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      dly_q     <= '0;
      rst_n_out <= '0;
      done      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dly_q     <= dly_d;
      rst_n_out <= rst_out_d;
      done      <= done_d;
      seq_err   <= err_d;
    end
  end

  assign state = state_q;

  // Next-state and next-output logic; a stage's reset bit is raised on the
  // edge that enters RELEASE so each stage goes high exactly once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dly_d     = dly_q;
    rst_out_d = rst_n_out;
    done_d    = done;
    err_d     = seq_err;

    if (soft_rst_req && (state_q != ST_RESET)) begin
      state_d   = ST_SETTLE;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rst_sync_n) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end

        ST_SETTLE: begin
          dly_d = dly_cfg;
          idx_d = '0;
          if (settle_end) begin
            state_d      = ST_RELEASE;
            cnt_d        = '0;
            rst_out_d[0] = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_RELEASE: begin
          state_d = ST_WAIT_ACK;
          cnt_d   = '0;
        end

        // Ack takes priority over a timeout landing in the same cycle.
        ST_WAIT_ACK: begin
          if (ack_s[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d   = ST_DONE;
              done_d    = 1'b1;
              rst_out_d = '1;
            end else begin
              state_d = ST_GAP;
            end
          end else if (tmo_end) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_GAP: begin
          if (gap_end) begin
            state_d            = ST_RELEASE;
            cnt_d              = '0;
            idx_d              = idx_inc;
            rst_out_d[idx_inc] = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_DONE: begin
          done_d    = 1'b1;
          rst_out_d = '1;
        end

        ST_FAULT: begin
          err_d = 1'b1;
        end

        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

endmodule
